universal_shift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with clock enable, synchronous reset to a parameter value, and four modes: hold, shift right, shift left, parallel load.
- Tracks the number of shifts since the last load. Pulses done when a full word has been shifted out.
- Serves as the common building block for serialisers, deserialisers and delay lines in the RTL collection.

---
 rtl/universal_shift_reg.sv | 86 ++++++++
 tb/tb_universal_shift_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// ============================================================================
// Module  : universal_shift_reg
// Brief   : WIDTH-bit register with hold / shift right / shift left / load,
//           saturating shift counter and a one-cycle full-word done pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module universal_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             w_shift;

  assign w_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {ser_in_msb, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_lsb};
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default:   q_d = q_q;
      endcase
    end
    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
    if (w_shift && (cnt_q != CNT_MAX)) begin
      cnt_d  = cnt_q + CW'(1);
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q           = q_q;
  assign ser_out_lsb = q_q[0];
  assign ser_out_msb = q_q[WIDTH-1];
  assign shift_cnt   = cnt_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// Module  : tb_universal_shift_reg
// Brief   : Scoreboard bench for universal_shift_reg (default and A5 reset).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst, en, sin_msb, sin_lsb;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic [W-1:0]  q_a, q_b;
  logic          sol_a, som_a, done_a, sol_b, som_b, done_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] qb;
    int           cnt;
    logic         done;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_q, m_qb;
  int           m_cnt;
  logic         m_done;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .ser_in_msb(sin_msb), .ser_in_lsb(sin_lsb),
    .q(q_a), .ser_out_lsb(sol_a), .ser_out_msb(som_a),
    .shift_cnt(cnt_a), .done(done_a)
  );

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .ser_in_msb(sin_msb), .ser_in_lsb(sin_lsb),
    .q(q_b), .ser_out_lsb(sol_b), .ser_out_msb(som_b),
    .shift_cnt(cnt_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, push the expectation, then pop and compare.
  task automatic cycle(input logic r, input logic e, input logic [1:0] m,
                       input logic [W-1:0] dv, input logic smsb, input logic slsb);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; mode = m; d = dv; sin_msb = smsb; sin_lsb = slsb;
    if (r) begin
      m_q = '0; m_qb = 8'hA5; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (e) begin
        if (m == M_LOAD) begin
          m_q = dv; m_qb = dv; m_cnt = 0;
        end else if (m == M_SHR || m == M_SHL) begin
          if (m == M_SHR) begin
            m_q  = {smsb, m_q[7:1]};
            m_qb = {smsb, m_qb[7:1]};
          end else begin
            m_q  = {m_q[6:0], slsb};
            m_qb = {m_qb[6:0], slsb};
          end
          if (m_cnt < W) begin
            m_done = (m_cnt == W - 1);
            m_cnt++;
          end
        end
      end
    end
    ex.q = m_q; ex.qb = m_qb; ex.cnt = m_cnt; ex.done = m_done;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      ex = sb.pop_front();
      check_eq("q",       32'(q_a),     32'(ex.q));
      check_eq("cnt",     32'(cnt_a),   32'(ex.cnt));
      check_eq("done",    32'(done_a),  32'(ex.done));
      check_eq("sol",     32'(sol_a),   32'(ex.q[0]));
      check_eq("som",     32'(som_a),   32'(ex.q[7]));
      check_eq("q_b",     32'(q_b),     32'(ex.qb));
      check_eq("cnt_b",   32'(cnt_b),   32'(ex.cnt));
      check_eq("done_b",  32'(done_b),  32'(ex.done));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq;
    logic [7:0] fill;
    rst = 1'b1; en = 1'b0; mode = M_HOLD; d = '0; sin_msb = 1'b0; sin_lsb = 1'b0;
    m_q = '0; m_qb = 8'hA5; m_cnt = 0; m_done = 1'b0;

    // Reset overrides en/load
    cycle(1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0);
    check_eq("rst_q",    32'(q_a),   32'h00);
    check_eq("rst_q_a5", 32'(q_b),   32'hA5);
    check_eq("rst_cnt",  32'(cnt_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);

    // Load then 8 right shifts, checking the bit stream leaving the LSB
    seq = 8'b1011_0010;
    cycle(1'b0, 1'b1, M_LOAD, seq, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq("sout_seq", 32'(sol_a), 32'(seq[i]));
      cycle(1'b0, 1'b1, M_SHR, 8'h00, 1'b0, 1'b0);
      check_eq("shr_done_once", 32'(done_a), (i == 7) ? 32'd1 : 32'd0);
    end
    check_eq("shr_final_q",   32'(q_a),   32'h00);
    check_eq("shr_final_cnt", 32'(cnt_a), 32'd8);

    // Left shifts with serial fill from zero
    cycle(1'b0, 1'b1, M_LOAD, 8'h00, 1'b0, 1'b0);
    fill = 8'b0101_0101;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, M_SHL, 8'h00, 1'b0, fill[i]);
    check_eq("shl_q_aa", 32'(q_a),    32'hAA);
    check_eq("shl_done", 32'(done_a), 32'd1);
    cycle(1'b0, 1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
    check_eq("shl9_q",    32'(q_a),    32'h54);
    check_eq("shl9_cnt",  32'(cnt_a),  32'd8);
    check_eq("shl9_done", 32'(done_a), 32'd0);

    // Enable gating
    cycle(1'b0, 1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, M_SHR, 8'hFF, 1'b1, 1'b1);
      check_eq("en_hold_q",   32'(q_a),   32'h3C);
      check_eq("en_hold_cnt", 32'(cnt_a), 32'd0);
    end
    cycle(1'b0, 1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
    check_eq("mode_hold_q", 32'(q_a), 32'h3C);

    // Reset mid-shift restarts the count
    cycle(1'b0, 1'b1, M_LOAD, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, M_SHR, 8'h00, 1'b0, 1'b0);
    check_eq("mid_cnt3", 32'(cnt_a), 32'd3);
    cycle(1'b1, 1'b1, M_SHR, 8'h00, 1'b1, 1'b0);
    check_eq("mid_rst_q",   32'(q_b),   32'hA5);
    check_eq("mid_rst_cnt", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, (i % 2 == 0) ? M_SHR : M_SHL, 8'h00, 1'b1, 1'b0);
      check_eq("mid_done8", 32'(done_a), (i == 7) ? 32'd1 : 32'd0);
    end

    // Load during shifting cancels the pending done
    cycle(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
    check_eq("ld_cnt7", 32'(cnt_a), 32'd7);
    cycle(1'b0, 1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0);
    check_eq("ld_q",    32'(q_a),    32'h5A);
    check_eq("ld_cnt",  32'(cnt_a),  32'd0);
    check_eq("ld_done", 32'(done_a), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) != 0),
            2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
